// File: rtl/minterm_scan_ctrl.sv
// Walks a combinational evaluator through every input combination and captures the
// resulting minterm mask and count. It also compares the mask against an expected mask.
module minterm_scan_ctrl #(
    parameter int N_VARS = 4,
    parameter int SETTLE = 1,
    parameter int M      = 2 ** N_VARS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [M-1:0]      expected,
    output logic [N_VARS-1:0] eval_in,
    input  logic              eval_f,
    output logic              busy,
    output logic              done,
    output logic [M-1:0]      mask,
    output logic [N_VARS:0]   count,
    output logic              match,
    output logic              err_valid,
    output logic [N_VARS-1:0] first_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_VARS-1:0] IDX_LAST    = '1;

    state_t              state_reg, state_next;
    logic [N_VARS-1:0]   idx_reg, idx_next;
    logic [3:0]          settle_reg, settle_next;
    logic [M-1:0]        exp_reg, exp_next;
    logic [M-1:0]        mask_reg, mask_next;
    logic [N_VARS:0]     count_reg, count_next;
    logic                match_reg, match_next;
    logic                err_valid_reg, err_valid_next;
    logic [N_VARS-1:0]   first_err_reg, first_err_next;
    logic [M-1:0]        mask_sampled;

    // Mask as it looks once the current index has been sampled.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_sample
            assign mask_sampled[gi] = (idx_reg == N_VARS'(gi)) ? eval_f : mask_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            settle_reg    <= '0;
            exp_reg       <= '0;
            mask_reg      <= '0;
            count_reg     <= '0;
            match_reg     <= 1'b0;
            err_valid_reg <= 1'b0;
            first_err_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            settle_reg    <= settle_next;
            exp_reg       <= exp_next;
            mask_reg      <= mask_next;
            count_reg     <= count_next;
            match_reg     <= match_next;
            err_valid_reg <= err_valid_next;
            first_err_reg <= first_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        settle_next    = settle_reg;
        exp_next       = exp_reg;
        mask_next      = mask_reg;
        count_next     = count_reg;
        match_next     = match_reg;
        err_valid_next = err_valid_reg;
        first_err_next = first_err_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = DRIVE;
                    exp_next       = expected;
                    mask_next      = '0;
                    count_next     = '0;
                    match_next     = 1'b0;
                    err_valid_next = 1'b0;
                    first_err_next = '0;
                    idx_next       = '0;
                    settle_next    = '0;
                end
            end
            DRIVE: begin
                // Abort beats the sample taken in the same cycle.
                if (abort) begin
                    state_next = IDLE;
                end else if (settle_reg == SETTLE_LAST) begin
                    mask_next  = mask_sampled;
                    count_next = count_reg + (N_VARS + 1)'(eval_f);
                    if ((eval_f != exp_reg[idx_reg]) && !err_valid_reg) begin
                        err_valid_next = 1'b1;
                        first_err_next = idx_reg;
                    end
                    if (idx_reg == IDX_LAST) begin
                        state_next = DONE;
                        // Match is already valid while done is high.
                        match_next = (mask_sampled == exp_reg);
                    end else begin
                        idx_next    = idx_reg + 1'b1;
                        settle_next = '0;
                    end
                end else begin
                    settle_next = settle_reg + 4'd1;
                end
            end
            DONE: begin
                match_next = (mask_reg == exp_reg);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign eval_in   = (state_reg == DRIVE) ? idx_reg : '0;
    assign busy      = (state_reg == DRIVE);
    assign done      = (state_reg == DONE);
    assign mask      = mask_reg;
    assign count     = count_reg;
    assign match     = match_reg;
    assign err_valid = err_valid_reg;
    assign first_err = first_err_reg;

endmodule

// File: tb/tb_minterm_scan_ctrl.sv
// Self-checking bench for minterm_scan_ctrl: directed test-plan scenarios plus random
// truth tables, expected masks and aborts, checked against a truth-table reference.
module tb_minterm_scan_ctrl;

    localparam int M = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] tt;

    logic        start_a, abort_a, f_a, busy_a, done_a, match_a, errv_a;
    logic [15:0] exp_a, mask_a;
    logic [3:0]  ein_a, ferr_a;
    logic [4:0]  count_a;

    logic        start_b, abort_b, f_b, busy_b, done_b, match_b, errv_b;
    logic [15:0] exp_b, mask_b;
    logic [3:0]  ein_b, ferr_b;
    logic [4:0]  count_b;

    assign f_a = tt[ein_a];
    assign f_b = tt[ein_b];

    minterm_scan_ctrl #(.N_VARS(4), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .expected(exp_a),
        .eval_in(ein_a), .eval_f(f_a), .busy(busy_a), .done(done_a), .mask(mask_a),
        .count(count_a), .match(match_a), .err_valid(errv_a), .first_err(ferr_a)
    );

    minterm_scan_ctrl #(.N_VARS(4), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .expected(exp_b),
        .eval_in(ein_b), .eval_f(f_b), .busy(busy_b), .done(done_b), .mask(mask_b),
        .count(count_b), .match(match_b), .err_valid(errv_b), .first_err(ferr_b)
    );

    int checks = 0;
    int errors = 0;

    int   trace_in [0:79];
    logic trace_busy [0:79];
    int   done_cyc;
    int   ndone;

    // Reference results
    logic [15:0] r_mask;
    logic [4:0]  r_count;
    logic        r_ev, r_match;
    logic [3:0]  r_fe;

    // Observed results
    logic [15:0] o_mask;
    logic [4:0]  o_count;
    logic        o_match, o_ev, o_busy, o_done;
    logic [3:0]  o_fe, o_ein;

    function automatic logic [15:0] xor_func_tt();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) begin
            logic a, b, c, d;
            a = ((i >> 3) & 1) != 0;
            b = ((i >> 2) & 1) != 0;
            c = ((i >> 1) & 1) != 0;
            d = (i & 1) != 0;
            t[i] = ((a & ~b) | (~a & b)) & (c | ~d);
        end
        return t;
    endfunction

    // Result after nsamp combinations have been sampled (16 = full scan).
    task automatic ref_model(input logic [15:0] t, input logic [15:0] e, input int nsamp);
        r_mask = '0; r_count = '0; r_ev = 1'b0; r_fe = '0;
        for (int i = 0; i < nsamp; i++) begin
            r_mask[i] = t[i];
            if (t[i]) r_count = r_count + 5'd1;
            if (t[i] != e[i] && !r_ev) begin
                r_ev = 1'b1;
                r_fe = 4'(i);
            end
        end
        r_match = (nsamp == 16) && (r_mask == e);
    endtask

    task automatic read_out(input int sel);
        if (sel == 0) begin
            o_mask = mask_a; o_count = count_a; o_match = match_a; o_ev = errv_a;
            o_fe = ferr_a; o_busy = busy_a; o_done = done_a; o_ein = ein_a;
        end else begin
            o_mask = mask_b; o_count = count_b; o_match = match_b; o_ev = errv_b;
            o_fe = ferr_b; o_busy = busy_b; o_done = done_b; o_ein = ein_b;
        end
    endtask

    task automatic set_ctl(input int sel, input logic s, input logic ab);
        if (sel == 0) begin start_a = s; abort_a = ab; end
        else          begin start_b = s; abort_b = ab; end
    endtask

    // Pulses start before edge 0, then records cycles 1..ncyc (no comparisons here).
    task automatic do_scan(input int sel, input logic [15:0] e, input int abort_cyc,
                           input bit repulse, input int ncyc);
        @(negedge clk);
        if (sel == 0) exp_a = e; else exp_b = e;
        set_ctl(sel, 1'b1, 1'b0);
        @(posedge clk);
        #1 set_ctl(sel, 1'b0, 1'b0);
        done_cyc = -1;
        ndone = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            read_out(sel);
            trace_in[c]   = int'(o_ein);
            trace_busy[c] = o_busy;
            if (o_done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            set_ctl(sel, repulse && (c == 5 || c == 17), c == abort_cyc);
        end
        set_ctl(sel, 1'b0, 1'b0);
        read_out(sel);
    endtask

    task automatic check_results(input string tag);
        checks++; if (o_mask !== r_mask) begin errors++;
            $display("FAIL %s mask got %h want %h", tag, o_mask, r_mask); end
        checks++; if (o_count !== r_count) begin errors++;
            $display("FAIL %s count got %0d want %0d", tag, o_count, r_count); end
        checks++; if (o_match !== r_match) begin errors++;
            $display("FAIL %s match got %b want %b", tag, o_match, r_match); end
        checks++; if (o_ev !== r_ev) begin errors++;
            $display("FAIL %s err_valid got %b want %b", tag, o_ev, r_ev); end
        checks++; if (r_ev && o_fe !== r_fe) begin errors++;
            $display("FAIL %s first_err got %0d want %0d", tag, o_fe, r_fe); end
        $display("scan %s: mask=%h count=%0d match=%b err=%b first_err=%0d done_cyc=%0d",
                 tag, o_mask, o_count, o_match, o_ev, o_fe, done_cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 0; abort_a = 0; exp_a = '0;
        start_b = 0; abort_b = 0; exp_b = '0;
        tt = '0;
        #12;
        read_out(0);
        checks++;
        if ({o_mask, o_count, o_match, o_ev, o_fe, o_busy, o_done, o_ein} !== '0) begin
            errors++;
            $display("FAIL reset outputs got %h want 0",
                     {o_mask, o_count, o_match, o_ev, o_fe, o_busy, o_done, o_ein});
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic(input logic [15:0] e, input string tag);
        tt = xor_func_tt();
        do_scan(0, e, 0, 1'b0, 20);
        checks++; if (done_cyc != 17 || ndone != 1) begin errors++;
            $display("FAIL %s done_cycle got %0d (x%0d) want 17", tag, done_cyc, ndone); end
        for (int c = 1; c <= 16; c++) begin
            checks++; if (trace_in[c] != c - 1) begin errors++;
                $display("FAIL %s eval_in cycle %0d got %0d want %0d", tag, c, trace_in[c], c - 1); end
        end
        ref_model(tt, e, 16);
        check_results(tag);
    endtask

    task automatic test_settle3();
        tt = xor_func_tt();
        do_scan(1, 16'h0DD0, 0, 1'b0, 52);
        checks++; if (done_cyc != 49 || ndone != 1) begin errors++;
            $display("FAIL settle3 done_cycle got %0d (x%0d) want 49", done_cyc, ndone); end
        for (int c = 1; c <= 48; c++) begin
            checks++; if (trace_in[c] != (c - 1) / 3) begin errors++;
                $display("FAIL settle3 eval_in cycle %0d got %0d want %0d", c, trace_in[c], (c - 1) / 3); end
        end
        ref_model(tt, 16'h0DD0, 16);
        check_results("settle3");
    endtask

    task automatic test_abort();
        tt = xor_func_tt();
        do_scan(0, 16'h0DD0, 6, 1'b0, 20);
        checks++; if (ndone != 0) begin errors++;
            $display("FAIL abort done_pulses got %0d want 0", ndone); end
        checks++; if (trace_busy[7] !== 1'b0 || trace_in[7] != 0) begin errors++;
            $display("FAIL abort cycle7 busy/eval_in got %b/%0d want 0/0", trace_busy[7], trace_in[7]); end
        ref_model(tt, 16'h0DD0, 5);
        checks++; if (o_mask !== 16'h0010) begin errors++;
            $display("FAIL abort mask_const got %h want 0010", o_mask); end
        check_results("abort");
        test_basic(16'h0DD0, "after_abort");
    endtask

    task automatic test_back_to_back();
        tt = xor_func_tt();
        do_scan(0, 16'h0DD0, 0, 1'b1, 22);
        checks++; if (done_cyc != 17 || ndone != 1) begin errors++;
            $display("FAIL restart_ignored done got cycle %0d x%0d want 17 x1", done_cyc, ndone); end
        checks++; if (trace_busy[19] !== 1'b0) begin errors++;
            $display("FAIL restart_ignored busy_after got %b want 0", trace_busy[19]); end
        ref_model(tt, 16'h0DD0, 16);
        check_results("restart_ignored");
    endtask

    task automatic test_reset_mid();
        tt = xor_func_tt();
        @(negedge clk);
        exp_a = 16'h0DD0; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        for (int c = 1; c <= 9; c++) @(negedge clk);
        rst_n = 1'b0;
        #1 read_out(0);
        checks++;
        if ({o_mask, o_count, o_match, o_ev, o_fe, o_busy, o_done, o_ein} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs got %h want 0",
                     {o_mask, o_count, o_match, o_ev, o_fe, o_busy, o_done, o_ein});
        end
        $display("reset applied mid-scan");
        @(negedge clk);
        rst_n = 1'b1;
        test_basic(16'h0DD0, "after_reset");
    endtask

    task automatic test_constant();
        tt = 16'hFFFF;
        do_scan(0, 16'hFFFF, 0, 1'b0, 20);
        ref_model(tt, 16'hFFFF, 16);
        check_results("const1");
        tt = 16'h0000;
        do_scan(0, 16'hFFFF, 0, 1'b0, 20);
        ref_model(tt, 16'hFFFF, 16);
        check_results("const0");
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int sel, s, ab, ns;
            logic [15:0] e;
            sel = int'($urandom_range(0, 1));
            s   = (sel == 0) ? 1 : 3;
            tt  = 16'($urandom);
            e   = ($urandom_range(0, 2) == 0) ? tt : (tt ^ 16'($urandom));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16 * s)) : 0;
            do_scan(sel, e, ab, 1'b0, 16 * s + 4);
            ns = (ab == 0) ? 16 : (ab - 1) / s;
            checks++;
            if ((ab == 0 && (done_cyc != 16 * s + 1 || ndone != 1)) || (ab != 0 && ndone != 0)) begin
                errors++;
                $display("FAIL random%0d done got cycle %0d x%0d abort %0d", it, done_cyc, ndone, ab);
            end
            ref_model(tt, e, ns);
            check_results($sformatf("random%0d_s%0d_ab%0d", it, s, ab));
        end
    endtask

    initial begin
        test_reset();
        test_basic(16'h0DD0, "basic");
        test_basic(16'h0DD1, "mismatch_lsb");
        test_basic(16'h0CD0, "mismatch_8");
        test_settle3();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_constant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
